// File: rtl/axis_decap_strip.sv
// axis_decap_strip: removes a tagged encapsulation header from AXI4-Stream
// packets and realigns the payload across beats. Untagged packets are
// forwarded unchanged. A single output register stage drives m_axis_*.
module axis_decap_strip #(
  parameter int          C_AXIS_DATA_WIDTH  = 256,
  parameter int          C_AXIS_TUSER_WIDTH = 128,
  parameter int          HDR_BYTES          = 8,
  parameter logic [15:0] ENCAP_TAG          = 16'h88B5
) (
  input  logic                            axis_aclk,
  input  logic                            reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [31:0]                     decap_count,
  output logic [31:0]                     drop_count
);
  localparam int W  = C_AXIS_DATA_WIDTH / 8;
  localparam int H  = HDR_BYTES;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam logic [15:0] H16 = 16'(HDR_BYTES);

  typedef enum logic [1:0] {IDLE, PASS, STRIP, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [W-H-1:0][7:0]    hold_q, hold_d;    // bytes [W-1:H] of the previous beat
  logic [W-H-1:0]         hkeep_q, hkeep_d;
  logic [UW-1:0]          user_q, user_d;
  logic                   first_q, first_d;  // next STRIP output is the packet's first

  logic [W-1:0][7:0]      cur;
  logic [W-1:0][7:0]      rd;
  logic [W-1:0]           rk;
  logic                   adv, acc, tag_hit;
  logic                   emit, e_last, pass_thru, use_hold, hi_en, inc_decap, inc_drop;
  logic [UW-1:0]          e_user, adj_s, adj_q;

  assign cur           = s_axis_tdata;
  assign adv           = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = adv && (state_q != FLUSH);
  assign acc           = s_axis_tvalid && s_axis_tready;
  assign tag_hit       = ({cur[0], cur[1]} == ENCAP_TAG);
  assign adj_s         = {s_axis_tuser[UW-1:16], s_axis_tuser[15:0] - H16};
  assign adj_q         = {user_q[UW-1:16], user_q[15:0] - H16};

  // Byte-lane realignment: low lanes take the shifted-down payload (from the
  // hold register or the current beat), high lanes take the current beat's
  // first H bytes when merging.
  for (genvar i = 0; i < W; i++) begin : g_lane
    if (i < W-H) begin : g_lo
      assign rd[i] = use_hold ? hold_q[i]  : cur[i+H];
      assign rk[i] = use_hold ? hkeep_q[i] : s_axis_tkeep[i+H];
    end else begin : g_hi
      assign rd[i] = hi_en ? cur[i-(W-H)] : 8'h00;
      assign rk[i] = hi_en & s_axis_tkeep[i-(W-H)];
    end
  end

  // Next-state and emit decisions; contiguous tkeep means n > H iff tkeep[H].
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    hkeep_d   = hkeep_q;
    user_d    = user_q;
    first_d   = first_q;
    emit      = 1'b0;
    e_last    = 1'b0;
    e_user    = '0;
    pass_thru = 1'b0;
    use_hold  = 1'b0;
    hi_en     = 1'b0;
    inc_decap = 1'b0;
    inc_drop  = 1'b0;
    unique case (state_q)
      IDLE: if (acc) begin
        user_d = s_axis_tuser;
        if (!tag_hit) begin
          emit = 1'b1; pass_thru = 1'b1; e_last = s_axis_tlast;
          if (!s_axis_tlast) state_d = PASS;
        end else if (s_axis_tlast) begin
          if (!s_axis_tkeep[H]) inc_drop = 1'b1;
          else begin
            emit = 1'b1; e_last = 1'b1; e_user = adj_s; inc_decap = 1'b1;
          end
        end else begin
          hold_d  = cur[W-1:H];
          hkeep_d = s_axis_tkeep[W-1:H];
          first_d = 1'b1;
          state_d = STRIP;
        end
      end
      PASS: if (acc) begin
        emit = 1'b1; pass_thru = 1'b1; e_last = s_axis_tlast;
        if (s_axis_tlast) state_d = IDLE;
      end
      STRIP: if (acc) begin
        emit     = 1'b1;
        use_hold = 1'b1;
        hi_en    = 1'b1;
        e_user   = first_q ? adj_q : '0;
        first_d  = 1'b0;
        hold_d   = cur[W-1:H];
        hkeep_d  = s_axis_tkeep[W-1:H];
        if (s_axis_tlast) begin
          if (!s_axis_tkeep[H]) begin
            e_last = 1'b1; inc_decap = 1'b1; state_d = IDLE;
          end else begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: if (adv) begin
        emit = 1'b1; use_hold = 1'b1; e_last = 1'b1; inc_decap = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and packet context registers.
  always_ff @(posedge axis_aclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      hkeep_q <= '0;
      user_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      hkeep_q <= hkeep_d;
      user_q  <= user_d;
      first_q <= first_d;
    end
  end

  // Output register: loads whenever it is free or being drained.
  always_ff @(posedge axis_aclk or posedge reset) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
    end else if (adv) begin
      m_axis_tvalid <= emit;
      if (emit) begin
        m_axis_tlast <= e_last;
        m_axis_tdata <= pass_thru ? s_axis_tdata : rd;
        m_axis_tkeep <= pass_thru ? s_axis_tkeep : rk;
        m_axis_tuser <= pass_thru ? s_axis_tuser : e_user;
      end
    end
  end

  // Packet counters, free-running with wrap.
  always_ff @(posedge axis_aclk or posedge reset) begin
    if (reset) begin
      decap_count <= '0;
      drop_count  <= '0;
    end else begin
      if (inc_decap) decap_count <= decap_count + 32'd1;
      if (inc_drop)  drop_count  <= drop_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_axis_decap_strip.sv
// Scoreboard bench for axis_decap_strip: a byte-level packet model fills an
// expected-beat queue, a negedge monitor pops and compares on each handshake.
module tb_axis_decap_strip;
  localparam int DW = 256, UW = 128, W = 32, H = 8;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [DW-1:0] data;
    logic [W-1:0]  keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic          clk = 1'b0, rst = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic [W-1:0]  s_tkeep = '0;
  logic [UW-1:0] s_tuser = '0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [DW-1:0] m_tdata;
  logic [W-1:0]  m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid, m_tlast, m_tready = 1'b1;
  logic [31:0]   decap_count, drop_count;

  beat_t expq[$];
  int    vectors = 0, errors = 0;
  int    exp_decap = 0, exp_drop = 0;
  bit    rdy_rand = 1'b0;
  bit    bub_en = 1'b0;
  int    bub_cnt = 0;

  axis_decap_strip dut (
    .axis_aclk(clk), .reset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .decap_count(decap_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: decide the fate of the packet from its bytes, build the
  // output byte stream, then cut it into W-byte beats.
  task automatic model(input bq_t b, input logic [UW-1:0] u);
    int len = b.size();
    bit match = (len >= 2) && (b[0] == 8'h88) && (b[1] == 8'hB5);
    bq_t ob;
    logic [UW-1:0] u0, un;
    beat_t e;
    if (match && len <= H) begin exp_drop++; return; end
    if (match) begin
      for (int i = H; i < len; i++) ob.push_back(b[i]);
      u0 = u; u0[15:0] = u[15:0] - 16'(H); un = '0;
      exp_decap++;
    end else begin
      ob = b; u0 = u; un = u;
    end
    for (int k = 0; k * W < ob.size(); k++) begin
      e.data = '0; e.keep = '0;
      for (int j = 0; j < W && k * W + j < ob.size(); j++) begin
        e.data[j*8 +: 8] = ob[k*W + j];
        e.keep[j] = 1'b1;
      end
      e.user = (k == 0) ? u0 : un;
      e.last = ((k + 1) * W >= ob.size());
      expq.push_back(e);
    end
  endtask

  task automatic make_pkt(input int len, input bit match, output bq_t b);
    b = {};
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
    if (match) begin b[0] = 8'h88; b[1] = 8'hB5; end
    else if (b[0] == 8'h88) b[0] = 8'h08;
  endtask

  // Drives one packet; abort_after >= 0 stops after that many accepted beats.
  task automatic send_pkt(input bq_t b, input int abort_after, input bit lat_chk, input bit gaps);
    int len = b.size();
    int nb = (len + W - 1) / W;
    bit match = (len >= 2) && (b[0] == 8'h88) && (b[1] == 8'hB5);
    bit fv = !match || (nb == 1 && len > H);
    logic [UW-1:0] u = {$urandom, $urandom, $urandom, 16'($urandom), 16'(len)};
    logic [DW-1:0] d;
    logic [W-1:0]  kp;
    int t;
    bit hs;
    model(b, u);
    for (int k = 0; k < nb; k++) begin
      if (k == abort_after) return;
      while (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      d = {8{$urandom}}; kp = '0;
      for (int j = 0; j < W; j++)
        if (k * W + j < len) begin d[j*8 +: 8] = b[k*W + j]; kp[j] = 1'b1; end
      s_tdata = d; s_tkeep = kp; s_tuser = u; s_tlast = (k == nb - 1); s_tvalid = 1'b1;
      t = 0; hs = 1'b0;
      while (!hs) begin
        @(negedge clk); hs = s_tready;
        @(posedge clk); #1;
        t++;
        if (!hs && t > 1000) begin
          check("s_handshake_timeout", 256'(0), 256'(1));
          s_tvalid = 1'b0;
          return;
        end
      end
      s_tvalid = 1'b0;
      if (lat_chk && k == 0) check("latency_first_beat", 256'(m_tvalid), 256'(fv));
      if (lat_chk && k == 1) check("latency_second_beat", 256'(m_tvalid), 256'(1'b1));
    end
  endtask

  task automatic drain_check(input string nm);
    int t = 0;
    while ((expq.size() != 0 || m_tvalid) && t < 3000) begin @(posedge clk); #1; t++; end
    if (t >= 3000) check({nm, "_drain_timeout"}, 256'(0), 256'(1));
    @(posedge clk); #1;
    check({nm, "_decap_count"}, 256'(decap_count), 256'(exp_decap));
    check({nm, "_drop_count"}, 256'(drop_count), 256'(exp_drop));
  endtask

  // Output ready: always 1, or a coin flip per cycle.
  always @(posedge clk) begin
    #1;
    m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) if (bub_en && !s_tready) bub_cnt++;

  // Monitor: compare each handshaken beat against the scoreboard, and check
  // that a stalled output holds still.
  beat_t         e_m;
  logic [DW-1:0] mk;
  logic [DW-1:0] p_d;
  logic [W-1:0]  p_k;
  logic [UW-1:0] p_u;
  logic          p_l, p_stall = 1'b0;
  always @(negedge clk) begin
    if (rst) p_stall = 1'b0;
    else begin
      if (p_stall) begin
        check("stall_tvalid", 256'(m_tvalid), 256'(1'b1));
        check("stall_tdata", 256'(m_tdata), 256'(p_d));
        check("stall_tkeep", 256'(m_tkeep), 256'(p_k));
        check("stall_tuser", 256'(m_tuser), 256'(p_u));
        check("stall_tlast", 256'(m_tlast), 256'(p_l));
      end
      if (m_tvalid && m_tready) begin
        if (expq.size() == 0) check("unexpected_output_beat", 256'(1), 256'(0));
        else begin
          e_m = expq.pop_front();
          mk = '0;
          for (int j = 0; j < W; j++) if (e_m.keep[j]) mk[j*8 +: 8] = 8'hFF;
          check("out_tdata", 256'(m_tdata & mk), 256'(e_m.data & mk));
          check("out_tkeep", 256'(m_tkeep), 256'(e_m.keep));
          check("out_tuser", 256'(m_tuser), 256'(e_m.user));
          check("out_tlast", 256'(m_tlast), 256'(e_m.last));
        end
      end
      p_stall = m_tvalid && !m_tready;
      p_d = m_tdata; p_k = m_tkeep; p_u = m_tuser; p_l = m_tlast;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1);
  end

  initial begin
    bq_t p;
    #12;
    check("rst_tvalid", 256'(m_tvalid), 256'(0));
    check("rst_tlast", 256'(m_tlast), 256'(0));
    check("rst_tdata", 256'(m_tdata), 256'(0));
    check("rst_tkeep", 256'(m_tkeep), 256'(0));
    check("rst_tuser", 256'(m_tuser), 256'(0));
    check("rst_decap", 256'(decap_count), 256'(0));
    check("rst_drop", 256'(drop_count), 256'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("tready_after_reset", 256'(s_tready), 256'(1));

    // Non-matching 64 bytes: straight through, one-cycle latency.
    make_pkt(64, 1'b0, p); p[0] = 8'h08; p[1] = 8'h00;
    send_pkt(p, -1, 1'b1, 1'b0); drain_check("pass64");

    // Matching 64 bytes.
    make_pkt(64, 1'b1, p); send_pkt(p, -1, 1'b1, 1'b0); drain_check("match64");

    // Matching 70 bytes: last beat fits, no flush bubble.
    bub_cnt = 0; bub_en = 1'b1;
    make_pkt(70, 1'b1, p); send_pkt(p, -1, 1'b1, 1'b0); drain_check("match70");
    bub_en = 1'b0;
    check("match70_bubbles", 256'(bub_cnt), 256'(0));

    // Matching 80 bytes: needs a flush beat, one input bubble.
    bub_cnt = 0; bub_en = 1'b1;
    make_pkt(80, 1'b1, p); send_pkt(p, -1, 1'b1, 1'b0); drain_check("match80");
    bub_en = 1'b0;
    check("match80_bubbles", 256'(bub_cnt), 256'(1));

    // Matching 8-byte packet is dropped; following packet intact.
    make_pkt(8, 1'b1, p); send_pkt(p, -1, 1'b1, 1'b0);
    make_pkt(40, 1'b0, p); send_pkt(p, -1, 1'b0, 1'b0); drain_check("drop8");

    // Random traffic with output backpressure and input gaps.
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      make_pkt((i % 8 == 0) ? $urandom_range(2, 12) : $urandom_range(2, 130),
               1'($urandom_range(0, 1)), p);
      send_pkt(p, -1, 1'b0, 1'b1);
    end
    drain_check("random");

    // Matching 200-byte packet cut by reset mid-packet.
    make_pkt(200, 1'b1, p); send_pkt(p, 4, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_tvalid", 256'(m_tvalid), 256'(0));
    check("midrst_decap", 256'(decap_count), 256'(0));
    check("midrst_drop", 256'(drop_count), 256'(0));
    expq.delete(); exp_decap = 0; exp_drop = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_tready", 256'(s_tready), 256'(1));

    // Traffic after reset recovers cleanly.
    make_pkt(100, 1'b1, p); send_pkt(p, -1, 1'b0, 1'b1);
    make_pkt(50, 1'b0, p); send_pkt(p, -1, 1'b0, 1'b1);
    drain_check("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/axis_decap_strip.md
# axis_decap_strip

AXI4-Stream decapsulator on the receive side of the encap/decap datapath, the inverse of the encapsulation stage. On the first beat of each packet it checks a 16-bit tag in the encapsulation header. Matching packets have their leading HDR_BYTES bytes removed, the payload realigned across beats, and the length in TUSER reduced. Non-matching packets pass through unchanged.

## Interface
- C_AXIS_DATA_WIDTH, 256, TDATA width in bits; W = C_AXIS_DATA_WIDTH/8 bytes per beat.
- C_AXIS_TUSER_WIDTH, 128, TUSER width; bits [15:0] hold the packet length in bytes.
- HDR_BYTES, 8, encapsulation header length H; legal range 2..W-1.
- ENCAP_TAG, 16'h88B5, tag value; compared against {byte0, byte1} of the first beat.
- axis_aclk  in  1  clock, all logic single-domain.
- reset  in  1  asynchronous, active-high reset.
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  W*8/W/TUSER/1/1  input stream.
- s_axis_tready  out  1  input ready.
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  W*8/W/TUSER/1/1  output stream.
- m_axis_tready  in  1  output ready.
- decap_count  out  32  packets decapsulated; wraps.
- drop_count  out  32  matching packets dropped as too short; wraps.

## Operation
- Byte 0 is TDATA[7:0]. TKEEP is contiguous from bit 0 and all-ones on non-last beats.
- State machine:
  - IDLE: awaits a first beat.
    - tag mismatch → output the beat as-is; go to PASS unless tlast.
    - tag match, tlast, valid bytes ≤ H → drop the packet, drop_count+1, stay IDLE.
    - tag match, tlast, valid bytes > H → emit one beat of (n−H) bytes with tlast; decap_count+1.
    - tag match, not tlast → store bytes [W−1:H] in the hold register; go to STRIP.
  - PASS: forward beats unchanged; tlast → IDLE.
  - STRIP: each accepted beat emits {cur[H−1:0], hold[W−1:H]} (held bytes low); hold ← cur.
    - Non-last beats emit W bytes.
    - Last beat with n ≤ H valid bytes: emit (W−H)+n bytes with tlast; decap_count+1; → IDLE.
    - Last beat with n > H: emit a full beat without tlast; → FLUSH.
  - FLUSH: s_axis_tready=0; emit the hold bytes (n−H bytes) with tlast; decap_count+1; → IDLE.
- TUSER: captured on the first beat.
  - Decapsulated packets: tuser[15:0] − H on the first output beat; other TUSER bits unchanged.
  - Non-first output beats carry TUSER = 0.
  - Passthrough packets keep TUSER unchanged.
- Counters saturate never; 32-bit wrap 0xFFFFFFFF→0.

## Timing
- Output register stage.
  - PASS/first-beat latency: 1 cycle from input handshake to m_axis_tvalid.
  - STRIP: the first output appears 1 cycle after the second input beat is accepted.
- s_axis_tready = (!m_axis_tvalid || m_axis_tready) && state != FLUSH. This gives full throughput when m_axis_tready=1.
- A drop consumes input beats with no output; tready follows the same rule.
- m_axis_* must hold stable while tvalid=1 && tready=0.
- A FLUSH beat adds exactly one bubble on the input.
- Reset (asynchronous, any time, including mid-packet):
  - state=IDLE; m_axis_tvalid=0, tlast=0, tdata=0, tkeep=0, tuser=0.
  - hold=0; decap_count=0, drop_count=0.
  - s_axis_tready=1 in the first cycle after reset deassertion.
  - A partially received packet is discarded; no tlast is emitted for it.
- Counter increments are visible the cycle after the last output beat is loaded into the output register.

## Test plan
- Non-matching 64-byte packet (tag 0x0800), m_axis_tready=1 → 2 identical output beats, 1-cycle latency, counters 0.
- Matching 64-byte packet, 2 beats, tuser[15:0]=64 → beat0 = in0 bytes[31:8] + in1 bytes[7:0]; beat1 tkeep=0x00FFFFFF, tlast; tuser[15:0]=56; decap_count=1.
- Matching 70-byte packet (last beat 6 bytes) → 2 output beats; last tkeep=0x3FFFFFFF; total 62 bytes; no FLUSH bubble.
- Matching 80-byte packet (last beat 16 bytes) → 3 output beats: 32, 32, 8 bytes; last tkeep=0xFF; s_axis_tready low exactly 1 cycle.
- Matching 8-byte single-beat packet, then a non-matching 40-byte packet → no output for the first packet; drop_count=1; the second packet is intact.
- Matching 200-byte packet with m_axis_tready random 50%, then reset asserted mid-packet → while the packet is in flight, output data matches the reference model byte-for-byte. Once reset asserts, m_axis_tvalid=0 asynchronously and both counters=0. The next packet is processed correctly.
